// File: rtl/score_display_mux_if.sv
// score_display_mux_if: groups the score inputs and the display outputs of
// score_display_mux.
//   score_a_i/score_b_i : binary scores from the counters (master -> slave)
//   seg_o               : active-high segments {g,f,e,d,c,b,a}
//   dig_sel_o           : one-hot digit enable (0 A tens, 1 A ones, 2 B tens, 3 B ones)
//   busy_o              : conversion in progress
interface score_display_mux_if #(
  parameter int BW = 7
);
  logic [BW-1:0] score_a_i;
  logic [BW-1:0] score_b_i;
  logic [6:0]    seg_o;
  logic [3:0]    dig_sel_o;
  logic          busy_o;

  modport master (output score_a_i, score_b_i, input seg_o, dig_sel_o, busy_o);
  modport slave  (input score_a_i, score_b_i, output seg_o, dig_sel_o, busy_o);
endinterface

// File: rtl/score_display_mux.sv
// score_display_mux: converts two binary scores (clamped to 0..99) to BCD with
// a sequential double-dabble engine and time-multiplexes the four resulting
// digits onto an active-high 7-segment display.
//   clk_i  : system clock
//   rst_ni : asynchronous active-low reset
//   bus    : score inputs, registered seg_o/dig_sel_o, busy_o
module score_display_mux #(
  parameter int BW          = 7,
  parameter int REFRESH_DIV = 1000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  score_display_mux_if.slave   bus
);

  localparam int CW = $clog2(BW + 1);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int DW = BW + 8;             // {tens, ones, binary}
  localparam logic [BW-1:0] MAX_SCORE = BW'(99);

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   clamp_a, clamp_b;
  logic [BW-1:0]   cap_a_q, cap_a_d, cap_b_q, cap_b_d;
  logic [BW-1:0]   last_a_q, last_a_d, last_b_q, last_b_d;
  logic            valid_q, valid_d;
  logic [DW-1:0]   dd_a_q, dd_a_d, dd_b_q, dd_b_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic            busy_q, busy_d;
  logic [3:0][3:0] disp_q, disp_d;
  logic [RW-1:0]   ref_cnt_q, ref_cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      dig_q, dig_d;
  logic [3:0]      cur_digit;

  // One double-dabble step: add 3 to any BCD nibble >= 5, then shift left.
  function automatic logic [DW-1:0] dd_step(input logic [DW-1:0] r);
    logic [DW-1:0] t;
    t = r;
    if (t[BW+3:BW] >= 4'd5)   t[BW+3:BW]   = t[BW+3:BW]   + 4'd3;
    if (t[BW+7:BW+4] >= 4'd5) t[BW+7:BW+4] = t[BW+7:BW+4] + 4'd3;
    return t << 1;
  endfunction

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  assign clamp_a = (bus.score_a_i > MAX_SCORE) ? MAX_SCORE : bus.score_a_i;
  assign clamp_b = (bus.score_b_i > MAX_SCORE) ? MAX_SCORE : bus.score_b_i;

  // Conversion FSM
  always_comb begin
    state_d   = state_q;
    cap_a_d   = cap_a_q;
    cap_b_d   = cap_b_q;
    last_a_d  = last_a_q;
    last_b_d  = last_b_q;
    valid_d   = valid_q;
    dd_a_d    = dd_a_q;
    dd_b_d    = dd_b_q;
    bit_cnt_d = bit_cnt_q;
    busy_d    = busy_q;
    disp_d    = disp_q;
    case (state_q)
      IDLE: begin
        if (!valid_q || clamp_a != last_a_q || clamp_b != last_b_q) begin
          cap_a_d   = clamp_a;
          cap_b_d   = clamp_b;
          dd_a_d    = {8'd0, clamp_a};
          dd_b_d    = {8'd0, clamp_b};
          bit_cnt_d = CW'(BW);
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        dd_a_d    = dd_step(dd_a_q);
        dd_b_d    = dd_step(dd_b_q);
        bit_cnt_d = bit_cnt_q - 1'b1;
        if (bit_cnt_q == CW'(1)) state_d = UPDATE;
      end
      UPDATE: begin
        // All four digits change together so the display never mixes scores.
        disp_d[0] = dd_a_q[BW+7:BW+4];
        disp_d[1] = dd_a_q[BW+3:BW];
        disp_d[2] = dd_b_q[BW+7:BW+4];
        disp_d[3] = dd_b_q[BW+3:BW];
        last_a_d  = cap_a_q;
        last_b_d  = cap_b_q;
        valid_d   = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Refresh scan and registered segment/digit outputs
  always_comb begin
    ref_cnt_d = ref_cnt_q + 1'b1;
    idx_d     = idx_q;
    if (ref_cnt_q == RW'(REFRESH_DIV - 1)) begin
      ref_cnt_d = '0;
      idx_d     = idx_q + 1'b1;
    end
    cur_digit = disp_q[idx_q];
    dig_d     = 4'b0001 << idx_q;
    seg_d     = decode(cur_digit);
    // Even indices are tens digits.
    if (BLANK_LZ && !idx_q[0] && cur_digit == 4'd0) seg_d = 7'h00;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cap_a_q   <= '0;
      cap_b_q   <= '0;
      last_a_q  <= '0;
      last_b_q  <= '0;
      valid_q   <= 1'b0;
      dd_a_q    <= '0;
      dd_b_q    <= '0;
      bit_cnt_q <= '0;
      busy_q    <= 1'b0;
      disp_q    <= '0;
      ref_cnt_q <= '0;
      idx_q     <= '0;
      seg_q     <= '0;
      dig_q     <= '0;
    end else begin
      state_q   <= state_d;
      cap_a_q   <= cap_a_d;
      cap_b_q   <= cap_b_d;
      last_a_q  <= last_a_d;
      last_b_q  <= last_b_d;
      valid_q   <= valid_d;
      dd_a_q    <= dd_a_d;
      dd_b_q    <= dd_b_d;
      bit_cnt_q <= bit_cnt_d;
      busy_q    <= busy_d;
      disp_q    <= disp_d;
      ref_cnt_q <= ref_cnt_d;
      idx_q     <= idx_d;
      seg_q     <= seg_d;
      dig_q     <= dig_d;
    end
  end

  assign bus.seg_o     = seg_q;
  assign bus.dig_sel_o = dig_q;
  assign bus.busy_o    = busy_q;

endmodule
